// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, scan counters, zero-skew sync/blank decode.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame_count output.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_tick
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0] frame_count
`endif
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             disp_q, disp_d;
    logic             tick_q, tick_d;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]       fcnt_q, fcnt_d;
`endif

    // Sync/blank flags are decoded from the next counter values so they land with the counters.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_en_d = (div_q == DIV_LAST);
        x_d      = x_q;
        y_d      = y_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        disp_d   = disp_q;

        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
            vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
            disp_d  = (x_d < H_VIS) && (y_d < V_VIS);
        end

        tick_d = pix_en_q && (x_d == '0) && (y_d == V_VIS);
`ifdef VGA_FRAME_CNT_EN
        fcnt_d = tick_d ? fcnt_q + 8'd1 : fcnt_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            disp_q   <= 1'b0;
            tick_q   <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            fcnt_q   <= '0;
`endif
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            tick_q   <= tick_d;
`ifdef VGA_FRAME_CNT_EN
            fcnt_q   <= fcnt_d;
`endif
        end
    end

    assign pix_en     = pix_en_q;
    assign CounterX   = x_q;
    assign CounterY   = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = disp_q;
    assign frame_tick = tick_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_count = fcnt_q;
`endif

endmodule
